// File: rtl/jedro_1_data_ram_if.sv
// Core-to-data-RAM bus: request, byte enables, address and write data from
// the core; read data, acknowledge and error back from the RAM.
interface jedro_1_data_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_i;
  logic [3:0]            we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  ack_o;
  logic                  err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o, err_o
  );
endinterface

// File: rtl/jedro_1_data_ram.sv
// Single-port data RAM for the jedro_1 core with a programmable number of
// wait states, byte-lane writes and a one-cycle ack/err response.
module jedro_1_data_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  jedro_1_data_ram_if.slave    bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  armed;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [3:0]            lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ack_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  accept;
  logic                  go_resp;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            cur_we;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_err;
  logic                  mem_we;

  // The transaction completing on this edge uses the live bus when it goes
  // straight from IDLE to RESP, otherwise the copies latched at acceptance.
  // armed blocks acceptance on the first edge after reset release, which also
  // keeps the memory write path independent of the reset net.
  always_comb begin
    accept    = (state == S_IDLE) && armed && bus.req_i;
    go_resp   = (accept && (WAIT_STATES == 0)) ||
                ((state == S_WAIT) && (cnt == 4'd1));
    cur_addr  = (state == S_IDLE) ? bus.addr_i  : lat_addr;
    cur_we    = (state == S_IDLE) ? bus.we_i    : lat_we;
    cur_wdata = (state == S_IDLE) ? bus.wdata_i : lat_wdata;
    cur_idx   = cur_addr[IDX_W+1:2];
    cur_err   = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (IDX_W + 2)) != '0);
    mem_we    = go_resp && !cur_err && (cur_we != 4'b0000);
  end

  // Control FSM, request latches and wait counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      armed     <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= '0;
      lat_wdata <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr  <= bus.addr_i;
            lat_we    <= bus.we_i;
            lat_wdata <= bus.wdata_i;
            cnt       <= 4'(WAIT_STATES);
            state     <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response registers: loaded on the edge entering RESP, cleared otherwise.
  // The read sees the pre-write word because the array updates on the same edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= go_resp;
      err_q   <= go_resp && cur_err;
      rdata_q <= (go_resp && !cur_err) ? mem[cur_idx] : '0;
    end
  end

  // Storage array: byte-lane writes, never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (cur_we[k]) mem[cur_idx][8*k +: 8] <= cur_wdata[8*k +: 8];
      end
    end
  end

  // Drive the bus outputs from the response registers.
  always_comb begin
    bus.rdata_o = rdata_q;
    bus.ack_o   = ack_q;
    bus.err_o   = err_q;
  end

endmodule

// File: tb/tb_jedro_1_data_ram.sv
// Directed bench for jedro_1_data_ram: one instance with no wait states and
// one with three, sharing the clock but with separate resets.
module tb_jedro_1_data_ram;

  logic clk = 1'b0;
  logic rstn0 = 1'b0;
  logic rstn3 = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  jedro_1_data_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
  jedro_1_data_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b3 ();

  jedro_1_data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(0))
    u_ws0 (.clk_i(clk), .rstn_i(rstn0), .bus(b0));
  jedro_1_data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(3))
    u_ws3 (.clk_i(clk), .rstn_i(rstn3), .bus(b3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic req, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      b0.req_i = req; b0.we_i = we; b0.addr_i = addr; b0.wdata_i = wd;
    end else begin
      b3.req_i = req; b3.we_i = we; b3.addr_i = addr; b3.wdata_i = wd;
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == 0) ? b0.ack_o : b3.ack_o;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? b0.err_o : b3.err_o;
  endfunction
  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? b0.rdata_o : b3.rdata_o;
  endfunction

  // One transaction. After the accept edge the request is dropped and the
  // other inputs scrambled, so the response must come from latched values.
  // lat counts falling edges from the accept edge to the first one seeing ack.
  task automatic txn(input int d, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output logic er, output int lat);
    @(negedge clk);
    drive(d, 1'b1, we, addr, wd);
    @(posedge clk);
    #1 drive(d, 1'b0, 4'hF, 32'h0000_0044, 32'hFFFF_FFFF);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_of(d) && lat < 40);
    rd = rd_of(d);
    er = err_of(d);
    if (!ack_of(d)) check("ack_timeout", 32'(ack_of(d)), 32'd1);
    drive(d, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("ack_width", 32'(ack_of(d)), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_ack0",  32'(b0.ack_o), 32'd0);
    check("rst_err0",  32'(b0.err_o), 32'd0);
    check("rst_rd0",   b0.rdata_o,    32'd0);
    check("rst_ack3",  32'(b3.ack_o), 32'd0);
    rstn0 = 1'b1;
    rstn3 = 1'b1;

    // No wait states: full-word write, then read back.
    txn(0, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("w0_lat", 32'(lat), 32'd1);
    check("w0_err", 32'(er),  32'd0);
    txn(0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    check("r0_lat",  32'(lat), 32'd1);
    check("r0_data", rd, 32'hDEADBEEF);

    // Byte lane 0 only; the write response shows the old word.
    txn(0, 4'b0001, 32'h10, 32'h00000011, rd, er, lat);
    check("wb_old", rd, 32'hDEADBEEF);
    txn(0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    check("rb_data", rd, 32'hDEADBE11);

    // Misaligned read.
    txn(0, 4'h0, 32'h12, 32'h0, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rd",  rd, 32'd0);
    check("mis_lat", 32'(lat), 32'd1);

    // Out-of-range write must not alias onto word 0.
    txn(0, 4'hF, 32'h0, 32'hCAFEF00D, rd, er, lat);
    txn(0, 4'hF, 32'h1000, 32'h11111111, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rd",  rd, 32'd0);
    txn(0, 4'h0, 32'h0, 32'h0, rd, er, lat);
    check("oor_keep", rd, 32'hCAFEF00D);
    check("oor_kerr", 32'(er), 32'd0);
    txn(0, 4'h0, 32'hFFC, 32'h0, rd, er, lat);
    check("top_err", 32'(er), 32'd0);

    // Back-to-back reads with req held high: acks two cycles apart.
    txn(0, 4'hF, 32'h100, 32'hA0A0A0A0, rd, er, lat);
    txn(0, 4'hF, 32'h104, 32'hB1B1B1B1, rd, er, lat);
    txn(0, 4'hF, 32'h108, 32'hC2C2C2C2, rd, er, lat);
    begin
      logic [31:0] exp_d [3];
      int gap;
      exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hB1B1B1B1; exp_d[2] = 32'hC2C2C2C2;
      @(negedge clk);
      drive(0, 1'b1, 4'h0, 32'h100, 32'h0);
      for (int i = 0; i < 3; i++) begin
        gap = 0;
        do begin
          @(negedge clk);
          gap++;
        end while (!b0.ack_o && gap < 20);
        check("b2b_gap", 32'(gap), (i == 0) ? 32'd1 : 32'd2);
        check("b2b_data", b0.rdata_o, exp_d[i]);
        drive(0, (i < 2), 4'h0, 32'h104 + 32'(4 * i), 32'h0);
      end
      @(negedge clk);
    end

    // Reset during RESP kills the response immediately.
    @(negedge clk);
    drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
    @(posedge clk);
    #1 drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("rr_ack_pre", 32'(b0.ack_o), 32'd1);
    rstn0 = 1'b0;
    #1;
    check("rr_ack", 32'(b0.ack_o), 32'd0);
    check("rr_rd",  b0.rdata_o,    32'd0);
    @(negedge clk);
    rstn0 = 1'b1;
    txn(0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    check("rr_keep", rd, 32'hDEADBE11);

    // Three wait states: latency and data.
    txn(3, 4'hF, 32'h10, 32'h12345678, rd, er, lat);
    check("w3_lat", 32'(lat), 32'd4);
    txn(3, 4'h0, 32'h10, 32'h0, rd, er, lat);
    check("r3_lat",  32'(lat), 32'd4);
    check("r3_data", rd, 32'h12345678);
    txn(3, 4'h0, 32'h13, 32'h0, rd, er, lat);
    check("e3_err", 32'(er), 32'd1);
    check("e3_lat", 32'(lat), 32'd4);

    // Reset during WAIT aborts a pending write.
    txn(3, 4'hF, 32'h20, 32'h0, rd, er, lat);
    @(negedge clk);
    drive(3, 1'b1, 4'hF, 32'h20, 32'h55);
    @(posedge clk);
    #1 drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    #2 rstn3 = 1'b0;
    #1;
    check("rw_ack", 32'(b3.ack_o), 32'd0);
    check("rw_err", 32'(b3.err_o), 32'd0);
    check("rw_rd",  b3.rdata_o,    32'd0);
    repeat (6) @(negedge clk);
    check("rw_noack", 32'(b3.ack_o), 32'd0);
    rstn3 = 1'b1;
    txn(3, 4'h0, 32'h20, 32'h0, rd, er, lat);
    check("rw_keep", rd, 32'h0);
    check("rw_lat",  32'(lat), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
